// File: rtl/iir_pkg.sv
// Constants shared by iir_filter and its downstream requantizer.
// Both blocks must agree on the accumulator format and the sample format.
package iir_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned ACC_WIDTH  = 32;
    localparam int unsigned FRAC_SHIFT = 15;

    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/window_peak_detector.sv
// Tracks max |sample| over fixed windows of 2**WINDOW_LOG2 valid samples.
// At the end of each window it publishes the peak and pulses peak_valid for one cycle.
module window_peak_detector
    import iir_pkg::*;
#(
    parameter int unsigned WIDTH       = DATA_WIDTH,
    parameter int unsigned WINDOW_LOG2 = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [WIDTH-1:0] sample,
    input  logic             clear,
    output logic [WIDTH-1:0] peak_abs,
    output logic             peak_valid
);

    localparam logic [WIDTH-1:0]       MagMax = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]       MagMin = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]       One    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WINDOW_LOG2-1:0] CntOne = {{(WINDOW_LOG2-1){1'b0}}, 1'b1};

    logic [WINDOW_LOG2-1:0] cnt_q;
    logic [WIDTH-1:0]       run_max_q;
    logic [WIDTH-1:0]       peak_abs_q;
    logic                   peak_valid_q;

    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] new_max;
    logic             last;

    // The most negative code has no positive twin; report it as full scale.
    always_comb begin
        mag = sample;
        if (sample[WIDTH-1]) begin
            if (sample == MagMin) begin
                mag = MagMax;
            end else begin
                mag = ~sample + One;
            end
        end
    end

    assign new_max = (mag > run_max_q) ? mag : run_max_q;
    assign last    = (cnt_q == {WINDOW_LOG2{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            run_max_q    <= '0;
            peak_abs_q   <= '0;
            peak_valid_q <= 1'b0;
        end else begin
            peak_valid_q <= 1'b0;
            if (clear) begin
                cnt_q     <= '0;
                run_max_q <= '0;
            end else if (valid) begin
                cnt_q <= cnt_q + CntOne;
                if (last) begin
                    peak_abs_q   <= new_max;
                    peak_valid_q <= 1'b1;
                    run_max_q    <= '0;
                end else begin
                    run_max_q <= new_max;
                end
            end
        end
    end

    assign peak_abs   = peak_abs_q;
    assign peak_valid = peak_valid_q;

endmodule

// File: rtl/iir_output_requantizer.sv
// Re-quantizes the iir_filter accumulator to a sample: round-half-up, shift, saturate.
// Also keeps clip telemetry and a windowed peak magnitude.
module iir_output_requantizer #(
    parameter int unsigned IN_WIDTH    = iir_pkg::ACC_WIDTH,
    parameter int unsigned OUT_WIDTH   = iir_pkg::DATA_WIDTH,
    parameter int unsigned FRAC_SHIFT  = iir_pkg::FRAC_SHIFT,
    parameter int unsigned WINDOW_LOG2 = 10,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  data_in,
    input  logic                 clear,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] data_out,
    output logic                 clip,
    output logic [OUT_WIDTH-1:0] peak_abs,
    output logic                 peak_valid,
    output logic [CNT_WIDTH-1:0] clip_count,
    output logic                 overflow_sticky
);

    // One extra bit so adding the rounding constant can never overflow.
    localparam int unsigned RW = IN_WIDTH + 1;

    localparam logic [RW-1:0] RoundHalf = {{(RW-1){1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
    localparam logic [RW-1:0] SatHiExt  = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [RW-1:0] SatLoExt  = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0] OutMax = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OutMin = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 v1_q;
    logic [RW-1:0]        r_q;
    logic [RW-1:0]        r_d;
    logic signed [RW-1:0] s;
    logic [OUT_WIDTH-1:0] sat_d;
    logic                 clip_d;

    logic                 out_valid_q;
    logic [OUT_WIDTH-1:0] data_q;
    logic                 clip_q;
    logic [CNT_WIDTH-1:0] clip_count_q;
    logic                 sticky_q;

    assign r_d = {data_in[IN_WIDTH-1], data_in} + RoundHalf;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            r_q  <= '0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                r_q <= r_d;
            end
        end
    end

    assign s = $signed(r_q) >>> FRAC_SHIFT;

    always_comb begin
        sat_d  = s[OUT_WIDTH-1:0];
        clip_d = 1'b0;
        if (s > $signed(SatHiExt)) begin
            sat_d  = OutMax;
            clip_d = 1'b1;
        end else if (s < $signed(SatLoExt)) begin
            sat_d  = OutMin;
            clip_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            clip_q      <= 1'b0;
        end else begin
            out_valid_q <= v1_q;
            if (v1_q) begin
                data_q <= sat_d;
                clip_q <= clip_d;
            end
        end
    end

    // Telemetry samples the registered outputs, so clear lands on the same edge as the update.
    always_ff @(posedge clk) begin
        if (rst) begin
            clip_count_q <= '0;
            sticky_q     <= 1'b0;
        end else if (clear) begin
            clip_count_q <= '0;
            sticky_q     <= 1'b0;
        end else if (out_valid_q && clip_q) begin
            sticky_q <= 1'b1;
            if (clip_count_q != {CNT_WIDTH{1'b1}}) begin
                clip_count_q <= clip_count_q + CntOne;
            end
        end
    end

    window_peak_detector #(
        .WIDTH       (OUT_WIDTH),
        .WINDOW_LOG2 (WINDOW_LOG2)
    ) u_peak (
        .clk        (clk),
        .rst        (rst),
        .valid      (out_valid_q),
        .sample     (data_q),
        .clear      (clear),
        .peak_abs   (peak_abs),
        .peak_valid (peak_valid)
    );

    assign out_valid       = out_valid_q;
    assign data_out        = data_q;
    assign clip            = clip_q;
    assign clip_count      = clip_count_q;
    assign overflow_sticky = sticky_q;

endmodule

// File: tb/tb_iir_output_requantizer.sv
// Self-checking bench for iir_output_requantizer (FRAC_SHIFT=15, WINDOW_LOG2=3).
// A scoreboard checks every output sample; scenario tasks check telemetry inline.
module tb_iir_output_requantizer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] data_in = '0;
    logic        clear = 1'b0;
    logic        out_valid;
    logic [15:0] data_out;
    logic        clip;
    logic [15:0] peak_abs;
    logic        peak_valid;
    logic [15:0] clip_count;
    logic        overflow_sticky;

    int tests  = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] d;
        logic        c;
        int          stamp;
    } sb_entry_t;

    sb_entry_t   sb[$];
    logic        have_last = 1'b0;
    logic [15:0] last_d = '0;
    logic        last_c = 1'b0;

    iir_output_requantizer #(
        .IN_WIDTH    (32),
        .OUT_WIDTH   (16),
        .FRAC_SHIFT  (15),
        .WINDOW_LOG2 (3),
        .CNT_WIDTH   (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .data_in         (data_in),
        .clear           (clear),
        .out_valid       (out_valid),
        .data_out        (data_out),
        .clip            (clip),
        .peak_abs        (peak_abs),
        .peak_valid      (peak_valid),
        .clip_count      (clip_count),
        .overflow_sticky (overflow_sticky)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: floor((x + 2^14) / 2^15) in 64-bit, then clamp to int16.
    function automatic logic [16:0] model(input logic [31:0] d);
        longint v;
        longint s;
        v = longint'($signed(d));
        s = (v + 64'sd16384) >>> 15;
        if (s > 64'sd32767) return {1'b1, 16'h7FFF};
        if (s < -64'sd32768) return {1'b1, 16'h8000};
        return {1'b0, s[15:0]};
    endfunction

    function automatic logic [31:0] samp(input int n);
        return 32'(n) << 15;
    endfunction

    always @(negedge clk) begin
        if (out_valid) begin
            tests++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: out_valid=1 data_out=%h with nothing expected", data_out);
            end else begin
                sb_entry_t e;
                e = sb.pop_front();
                if (data_out !== e.d || clip !== e.c || cyc != e.stamp + 2) begin
                    errors++;
                    $display("FAIL sb_sample: got data=%h clip=%b cyc=%0d, want data=%h clip=%b cyc=%0d",
                             data_out, clip, cyc, e.d, e.c, e.stamp + 2);
                end
                have_last = 1'b1;
                last_d    = e.d;
                last_c    = e.c;
            end
        end else if (have_last) begin
            tests++;
            if (data_out !== last_d || clip !== last_c) begin
                errors++;
                $display("FAIL hold: got data=%h clip=%b, want data=%h clip=%b",
                         data_out, clip, last_d, last_c);
            end
        end
    end

    task automatic cycle(input logic v, input logic [31:0] d, input logic clr);
        sb_entry_t   e;
        logic [16:0] m;
        in_valid = v;
        data_in  = d;
        clear    = clr;
        if (v) begin
            m       = model(d);
            e.d     = m[15:0];
            e.c     = m[16];
            e.stamp = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        clear    = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        have_last = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({out_valid, data_out, clip, peak_abs, peak_valid, clip_count, overflow_sticky} !== '0) begin
            errors++;
            $display("FAIL reset_state: ov=%b d=%h c=%b pk=%h pv=%b cnt=%h st=%b, want all 0",
                     out_valid, data_out, clip, peak_abs, peak_valid, clip_count, overflow_sticky);
        end
    endtask

    task automatic test_rounding();
        logic [31:0] vin[3];
        logic [15:0] vexp[3];
        vin  = '{32'h0000_4000, 32'h0000_3FFF, 32'hFFFF_C000};
        vexp = '{16'h0001, 16'h0000, 16'h0000};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, vin[i], 1'b0);
            cycle(1'b0, '0, 1'b0);
            tests++;
            if (out_valid !== 1'b1 || data_out !== vexp[i] || clip !== 1'b0) begin
                errors++;
                $display("FAIL round_%0d: ov=%b data=%h clip=%b, want ov=1 data=%h clip=0",
                         i, out_valid, data_out, clip, vexp[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [31:0] vin[2];
        logic [15:0] vexp[2];
        vin  = '{32'h4000_0000, 32'h8000_0000};
        vexp = '{16'h7FFF, 16'h8000};
        do_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, vin[i], 1'b0);
            cycle(1'b0, '0, 1'b0);
            tests++;
            if (data_out !== vexp[i] || clip !== 1'b1) begin
                errors++;
                $display("FAIL sat_%0d: data=%h clip=%b, want data=%h clip=1",
                         i, data_out, clip, vexp[i]);
            end
        end
        cycle(1'b0, '0, 1'b0);
        tests++;
        if (clip_count !== 16'd2 || overflow_sticky !== 1'b1) begin
            errors++;
            $display("FAIL sat_telemetry: count=%0d sticky=%b, want count=2 sticky=1",
                     clip_count, overflow_sticky);
        end
    endtask

    task automatic test_bubbles();
        logic v[6];
        v = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            cycle(v[k], samp(k + 1), 1'b0);
            tests++;
            if (out_valid !== ((k == 0) ? 1'b0 : v[k-1])) begin
                errors++;
                $display("FAIL bubble_valid_%0d: out_valid=%b, want %b",
                         k, out_valid, (k == 0) ? 1'b0 : v[k-1]);
            end
            if (k == 2) begin
                tests++;
                if (data_out !== 16'h0001) begin
                    errors++;
                    $display("FAIL bubble_hold: data=%h, want 0001", data_out);
                end
            end
        end
    endtask

    task automatic test_window();
        do_reset();
        for (int k = 0; k < 12; k++) begin
            cycle(k < 8, (k == 4) ? 32'h8000_0000 : samp(k + 1), 1'b0);
            tests++;
            if (peak_valid !== (k == 9)) begin
                errors++;
                $display("FAIL win1_pv_%0d: peak_valid=%b, want %b", k, peak_valid, k == 9);
            end
            if (k == 9) begin
                tests++;
                if (peak_abs !== 16'h7FFF) begin
                    errors++;
                    $display("FAIL win1_peak: peak_abs=%h, want 7FFF", peak_abs);
                end
            end
        end
        for (int k = 0; k < 12; k++) begin
            cycle(k < 8, samp(3), 1'b0);
            tests++;
            if (peak_valid !== (k == 9)) begin
                errors++;
                $display("FAIL win2_pv_%0d: peak_valid=%b, want %b", k, peak_valid, k == 9);
            end
            if (k == 8 || k == 9) begin
                tests++;
                if (peak_abs !== ((k == 8) ? 16'h7FFF : 16'h0003)) begin
                    errors++;
                    $display("FAIL win2_peak_%0d: peak_abs=%h, want %h",
                             k, peak_abs, (k == 8) ? 16'h7FFF : 16'h0003);
                end
            end
        end
        tests++;
        if (clip_count !== 16'd1 || overflow_sticky !== 1'b1) begin
            errors++;
            $display("FAIL win_clips: count=%0d sticky=%b, want 1/1", clip_count, overflow_sticky);
        end
    endtask

    task automatic test_clear();
        do_reset();
        cycle(1'b1, 32'h4000_0000, 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1);
        tests++;
        if (clip_count !== 16'd0 || overflow_sticky !== 1'b0) begin
            errors++;
            $display("FAIL clear_wins: count=%0d sticky=%b, want 0/0", clip_count, overflow_sticky);
        end
        cycle(1'b1, 32'h4000_0000, 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        tests++;
        if (clip_count !== 16'd1 || overflow_sticky !== 1'b1) begin
            errors++;
            $display("FAIL clear_next: count=%0d sticky=%b, want 1/1", clip_count, overflow_sticky);
        end
        // Clear on the window-closing edge must suppress the pulse.
        do_reset();
        for (int k = 0; k < 12; k++) begin
            cycle(k < 8, samp(5), k == 9);
            tests++;
            if (peak_valid !== 1'b0 || peak_abs !== 16'h0000) begin
                errors++;
                $display("FAIL clear_window_%0d: pv=%b peak=%h, want 0/0000", k, peak_valid, peak_abs);
            end
        end
    endtask

    task automatic test_reset_mid_window();
        do_reset();
        for (int k = 0; k < 5; k++) cycle(1'b1, samp(7), 1'b0);
        do_reset();
        tests++;
        if ({out_valid, data_out, clip, peak_abs, peak_valid, clip_count, overflow_sticky} !== '0) begin
            errors++;
            $display("FAIL midreset_state: ov=%b d=%h c=%b pk=%h pv=%b cnt=%h st=%b, want all 0",
                     out_valid, data_out, clip, peak_abs, peak_valid, clip_count, overflow_sticky);
        end
        for (int k = 0; k < 12; k++) begin
            cycle(k < 8, samp(2), 1'b0);
            tests++;
            if (peak_valid !== (k == 9)) begin
                errors++;
                $display("FAIL midreset_pv_%0d: peak_valid=%b, want %b", k, peak_valid, k == 9);
            end
            if (k == 8 || k == 9) begin
                tests++;
                if (peak_abs !== ((k == 8) ? 16'h0000 : 16'h0002)) begin
                    errors++;
                    $display("FAIL midreset_peak_%0d: peak_abs=%h, want %h",
                             k, peak_abs, (k == 8) ? 16'h0000 : 16'h0002);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_rounding();
        test_saturation();
        test_bubbles();
        test_window();
        test_clear();
        test_reset_mid_window();
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        tests++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d samples outstanding, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
